// File: rtl/lut_config_loader.sv
// lut_config_loader
// Streams NUM_LUTS truth-table words, LSB first, into a daisy-chain of
// 16-bit configuration shift registers while holding the fabric in
// configuration mode (prgm_b low). Outputs are registered from next-state
// values, so they change only on clk edges and never glitch.
module lut_config_loader #(
   parameter int NUM_LUTS = 4,
   parameter int LUT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LUT_W-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             prgm_b,
   output logic             cfg_shift_en,
   output logic             cfg_data,
   output logic             busy,
   output logic             done
);

   localparam int                WCNT_W   = $clog2(NUM_LUTS + 1);
   localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NUM_LUTS - 1);
   localparam logic [3:0]        BIT_LAST = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [LUT_W-1:0]   hold_q, hold_d;

   logic word_ready_q, word_ready_d;
   logic prgm_b_q, prgm_b_d;
   logic shift_en_q, shift_en_d;
   logic cfg_data_q, cfg_data_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   // State, counters, holding register and registered outputs; reset forces the idle/user-mode values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         word_cnt_q   <= '0;
         bit_cnt_q    <= 4'd0;
         hold_q       <= '0;
         word_ready_q <= 1'b0;
         prgm_b_q     <= 1'b1;
         shift_en_q   <= 1'b0;
         cfg_data_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         hold_q       <= hold_d;
         word_ready_q <= word_ready_d;
         prgm_b_q     <= prgm_b_d;
         shift_en_q   <= shift_en_d;
         cfg_data_q   <= cfg_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next-state logic: accept a word in LOAD, shift its 16 bits, repeat until the chain is full.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      hold_d     = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD;
               word_cnt_d = '0;
               bit_cnt_d  = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            // word_ready is high throughout LOAD, so word_valid alone completes the handshake
            if (word_valid) begin
               hold_d    = word_in;
               bit_cnt_d = 4'd0;
               state_d   = ST_SHIFT;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt_q == BIT_LAST) begin
               word_cnt_d = word_cnt_q + WCNT_W'(1);
               if (word_cnt_q == LAST_IDX) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output leaves a flop aligned with its state.
   always_comb begin
      word_ready_d = 1'b0;
      shift_en_d   = 1'b0;
      cfg_data_d   = 1'b0;
      prgm_b_d     = 1'b1;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      case (state_d)
         ST_IDLE: begin
            // a return from FINISH is the only way to complete a load
            done_d = (state_q == ST_FINISH);
         end
         ST_LOAD: begin
            word_ready_d = 1'b1;
            prgm_b_d     = 1'b0;
            busy_d       = 1'b1;
         end
         ST_SHIFT: begin
            shift_en_d = 1'b1;
            cfg_data_d = hold_d[bit_cnt_d];
            prgm_b_d   = 1'b0;
            busy_d     = 1'b1;
         end
         ST_FINISH: begin
            prgm_b_d = 1'b0;
            busy_d   = 1'b1;
         end
         default: begin
            prgm_b_d = 1'b1;
         end
      endcase
   end

   assign word_ready   = word_ready_q;
   assign prgm_b       = prgm_b_q;
   assign cfg_shift_en = shift_en_q;
   assign cfg_data     = cfg_data_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader
// Drives a 4-LUT loader with random and directed words and a 1-LUT loader
// with a fixed word, checking against a behavioural LUT chain, an expected
// bit stream and event counters.
module tb_lut_config_loader;

   localparam int NL = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic        start4 = 1'b0, word_valid4 = 1'b0;
   logic [15:0] word_in4 = 16'h0000;
   logic        word_ready4, prgm_b4, shift_en4, cfg_data4, busy4, done4;

   logic        start1 = 1'b0, word_valid1 = 1'b0;
   logic [15:0] word_in1 = 16'h0000;
   logic        word_ready1, prgm_b1, shift_en1, cfg_data1, busy1, done1;

   int n_tests = 0;
   int n_fail  = 0;

   // reference / monitor state
   logic [15:0] chain [NL];
   logic [15:0] words [NL];
   int          stalls [NL];
   bit          obs_bits [$];
   int          shift_cnt = 0;
   int          done_cnt = 0;
   int          busy_fall = 0;
   logic        busy_prev = 1'b0;

   lut_config_loader #(.NUM_LUTS(NL), .LUT_W(16)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .word_in(word_in4),
      .word_valid(word_valid4), .word_ready(word_ready4), .prgm_b(prgm_b4),
      .cfg_shift_en(shift_en4), .cfg_data(cfg_data4), .busy(busy4), .done(done4)
   );

   lut_config_loader #(.NUM_LUTS(1), .LUT_W(16)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .word_in(word_in1),
      .word_valid(word_valid1), .word_ready(word_ready1), .prgm_b(prgm_b1),
      .cfg_shift_en(shift_en1), .cfg_data(cfg_data1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   // Behavioural chain: each enabled cycle shifts cfg_data into LUT0 bit 15, LUTj bit 0 feeds LUTj+1.
   always @(negedge clk) begin
      if (shift_en4) begin
         shift_cnt++;
         obs_bits.push_back(cfg_data4);
         for (int j = NL - 1; j >= 1; j--) chain[j] = {chain[j-1][0], chain[j][15:1]};
         chain[0] = {cfg_data4, chain[0][15:1]};
      end
      if (done4) done_cnt++;
      if (busy_prev && !busy4) busy_fall++;
      busy_prev = busy4;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Offer one word once the loader is in LOAD, after 'stall' idle LOAD cycles.
   task automatic send_word(input logic [15:0] w, input int stall);
      int guard = 0;
      word_valid4 = 1'b0;
      while (!word_ready4 && guard < 100) begin @(negedge clk); guard++; end
      n_tests++;
      if (!word_ready4) begin
         n_fail++;
         $display("FAIL word_ready_timeout: word_ready=%b required 1", word_ready4);
      end
      for (int s = 0; s < stall; s++) begin
         n_tests++;
         if (shift_en4 !== 1'b0 || word_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_gap: shift_en=%b ready=%b required 0/1", shift_en4, word_ready4);
         end
         @(negedge clk);
      end
      word_in4 = w;
      word_valid4 = 1'b1;
      @(negedge clk);
      word_valid4 = 1'b0;
      word_in4 = 16'($urandom);
   endtask

   // Full load of words[] with stalls[]; caller is at a negedge with the DUT idle.
   task automatic run_load(input bit poke_start);
      int guard = 0;
      bit exp_bits [$];
      shift_cnt = 0; done_cnt = 0; busy_fall = 0; obs_bits.delete();
      for (int j = 0; j < NL; j++)
         for (int k = 0; k < 16; k++) exp_bits.push_back(words[j][k]);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      n_tests++;
      if (prgm_b4 !== 1'b0 || busy4 !== 1'b1 || word_ready4 !== 1'b1) begin
         n_fail++;
         $display("FAIL load_entry: prgm_b=%b busy=%b ready=%b required 0/1/1", prgm_b4, busy4, word_ready4);
      end
      for (int i = 0; i < NL; i++) begin
         send_word(words[i], stalls[i]);
         if (poke_start && i == 0) begin
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
         end
      end
      while (!done4 && guard < 200) begin @(negedge clk); guard++; end
      n_tests++;
      if (done4 !== 1'b1 || prgm_b4 !== 1'b1 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL done_state: done=%b prgm_b=%b busy=%b required 1/1/0", done4, prgm_b4, busy4);
      end
      @(negedge clk);
      n_tests++;
      if (done4 !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse_width: done=%b required 0", done4);
      end
      n_tests++;
      if (shift_cnt != 16 * NL || done_cnt != 1 || busy_fall != 1) begin
         n_fail++;
         $display("FAIL load_counts: shifts=%0d done=%0d busy_falls=%0d required %0d/1/1",
                  shift_cnt, done_cnt, busy_fall, 16 * NL);
      end
      n_tests++;
      if (obs_bits.size() != exp_bits.size() || obs_bits != exp_bits) begin
         n_fail++;
         $display("FAIL bit_stream: got %0d bits, required %0d bits in order", obs_bits.size(), exp_bits.size());
      end
      for (int j = 0; j < NL; j++) begin
         n_tests++;
         if (chain[NL-1-j] !== words[j]) begin
            n_fail++;
            $display("FAIL chain_lut%0d: got %h required %h", NL - 1 - j, chain[NL-1-j], words[j]);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start4 = 1'b1; start1 = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({word_ready4, prgm_b4, shift_en4, cfg_data4, busy4, done4} !== 6'b010000 ||
          {word_ready1, prgm_b1, shift_en1, cfg_data1, busy1, done1} !== 6'b010000) begin
         n_fail++;
         $display("FAIL reset_values: dut4=%b dut1=%b required 010000",
                  {word_ready4, prgm_b4, shift_en4, cfg_data4, busy4, done4},
                  {word_ready1, prgm_b1, shift_en1, cfg_data1, busy1, done1});
      end
      reset = 1'b1; start4 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy4 !== 1'b0 || prgm_b4 !== 1'b1 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL start_during_reset: busy4=%b prgm_b4=%b busy1=%b required 0/1/0", busy4, prgm_b4, busy1);
      end
   endtask

   task automatic test_valid_outside_load;
      int sc = shift_cnt;
      for (int c = 0; c < 4; c++) begin
         word_in4 = 16'($urandom); word_valid4 = 1'b1;
         @(negedge clk);
         n_tests++;
         if (word_ready4 !== 1'b0 || busy4 !== 1'b0 || shift_cnt != sc) begin
            n_fail++;
            $display("FAIL valid_in_idle: ready=%b busy=%b shifts=%0d required 0/0/%0d", word_ready4, busy4, shift_cnt, sc);
         end
      end
      word_valid4 = 1'b0;
   endtask

   task automatic test_single_lut;
      int exp_list [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      word_in1 = 16'hA5C3; word_valid1 = 1'b1;
      @(negedge clk);
      word_valid1 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (shift_en1 !== 1'b1 || cfg_data1 !== exp_list[k][0]) begin
            n_fail++;
            $display("FAIL single_shift_%0d: en=%b data=%b required 1/%0d", k, shift_en1, cfg_data1, exp_list[k]);
         end
         @(negedge clk);
      end
      n_tests++;
      if (shift_en1 !== 1'b0 || prgm_b1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL single_finish: en=%b prgm_b=%b done=%b busy=%b required 0/0/0/1", shift_en1, prgm_b1, done1, busy1);
      end
      @(negedge clk);
      n_tests++;
      if (done1 !== 1'b1 || prgm_b1 !== 1'b1 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b prgm_b=%b busy=%b required 1/1/0", done1, prgm_b1, busy1);
      end
      @(negedge clk);
   endtask

   task automatic test_directed_chain;
      words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF; words[3] = 16'h0000;
      stalls[0] = 0; stalls[1] = 5; stalls[2] = 0; stalls[3] = 0;
      run_load(1'b0);
      n_tests++;
      if (chain[3][0] !== 1'b1 || chain[2][15] !== 1'b1) begin
         n_fail++;
         $display("FAIL directed_bits: lut3[0]=%b lut2[15]=%b required 1/1", chain[3][0], chain[2][15]);
      end
   endtask

   task automatic test_random_loads;
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < NL; j++) begin
            words[j] = 16'($urandom);
            stalls[j] = $urandom_range(0, 6);
         end
         run_load(1'b0);
      end
   endtask

   task automatic test_start_during_shift;
      for (int j = 0; j < NL; j++) begin words[j] = 16'($urandom); stalls[j] = 0; end
      run_load(1'b1);
      repeat (4) @(negedge clk);
      n_tests++;
      if (busy4 !== 1'b0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL start_not_queued: busy=%b done_count=%0d required 0/1", busy4, done_cnt);
      end
   endtask

   task automatic test_reset_mid_shift;
      done_cnt = 0;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      send_word(16'($urandom), 0);
      send_word(16'($urandom), 0);
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({word_ready4, prgm_b4, shift_en4, cfg_data4, busy4, done4} !== 6'b010000) begin
         n_fail++;
         $display("FAIL reset_mid_shift: outputs=%b required 010000",
                  {word_ready4, prgm_b4, shift_en4, cfg_data4, busy4, done4});
      end
      reset = 1'b1;
      repeat (5) @(negedge clk);
      n_tests++;
      if (done_cnt != 0 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: done_count=%0d busy=%b required 0/0", done_cnt, busy4);
      end
      for (int j = 0; j < NL; j++) begin words[j] = 16'($urandom); stalls[j] = $urandom_range(0, 3); end
      run_load(1'b0);
   endtask

   task automatic test_back_to_back;
      for (int j = 0; j < NL; j++) begin words[j] = 16'($urandom); stalls[j] = 0; end
      run_load(1'b0);
      for (int j = 0; j < NL; j++) begin words[j] = 16'($urandom); stalls[j] = 1; end
      run_load(1'b0);
   endtask

   initial begin
      for (int j = 0; j < NL; j++) chain[j] = 16'h0000;
      @(negedge clk);
      test_reset();
      test_valid_outside_load();
      test_single_lut();
      test_directed_chain();
      test_random_loads();
      test_start_during_shift();
      test_reset_mid_shift();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
